// File: rtl/gemm_isa_pkg.sv
// gemm_isa_pkg: GEMM accelerator ISA field layout, opcodes, legality check and fetch FSM states
package gemm_isa_pkg;
  localparam int INST_W = 16;
  localparam int OPCODE_W = 4;
  localparam int BUF_ID_W = 2;
  localparam int MEM_LOC_W = 10;
  localparam int OPCODE_ARRAY_INDEX = 16;
  localparam int BUF_ID_ARRAY_INDEX = 12;
  localparam int MEM_LOC_ARRAY_INDEX = 10;
  localparam logic [OPCODE_W-1:0] opcode_LD = 4'b0010;
  localparam logic [OPCODE_W-1:0] opcode_ST = 4'b0011;
  localparam logic [OPCODE_W-1:0] opcode_GEMM = 4'b0100;
  localparam logic [OPCODE_W-1:0] opcode_DRAINSYS = 4'b0101;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;
  function automatic logic opcode_legal(input logic [OPCODE_W-1:0] op);
    return op inside {opcode_LD, opcode_ST, opcode_GEMM, opcode_DRAINSYS};
  endfunction
endpackage

// File: rtl/inst_decode.sv
// inst_decode: splits an instruction word into opcode/buf_id/mem_loc and flags legal opcodes
module inst_decode
  import gemm_isa_pkg::*;
(
  input  logic [INST_W-1:0]    word,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [BUF_ID_W-1:0]  buf_id,
  output logic [MEM_LOC_W-1:0] mem_loc,
  output logic                 legal
);
  assign opcode = word[OPCODE_ARRAY_INDEX-1 -: OPCODE_W];
  assign buf_id = word[BUF_ID_ARRAY_INDEX-1 -: BUF_ID_W];
  assign mem_loc = word[MEM_LOC_ARRAY_INDEX-1 -: MEM_LOC_W];
  assign legal = opcode_legal(opcode);
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: program store + sequencer issuing legal instructions under valid/ready; INST_FETCH_PREFETCH_EN adds a prefetch register for 1 inst/cycle
module inst_fetch
  import gemm_isa_pkg::*;
#(
  parameter int INST_WIDTH = 16,
  parameter int INST_MEMORY_SIZE = 6,
  parameter int LOG2_INST_MEMORY_SIZE = 3,
  parameter int OPCODE_WIDTH = 4,
  parameter int BUF_ID_WIDTH = 2,
  parameter int MEM_LOC_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_prog_wr_en,
  input  logic [LOG2_INST_MEMORY_SIZE-1:0] i_prog_wr_addr,
  input  logic [INST_WIDTH-1:0]          i_prog_wr_data,
  input  logic [LOG2_INST_MEMORY_SIZE:0] i_prog_len,
  input  logic                           i_start,
  output logic                           o_inst_valid,
  input  logic                           i_inst_ready,
  output logic [OPCODE_WIDTH-1:0]        o_opcode,
  output logic [BUF_ID_WIDTH-1:0]        o_buf_id,
  output logic [MEM_LOC_WIDTH-1:0]       o_mem_loc,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err
);
  localparam logic [LOG2_INST_MEMORY_SIZE:0] DEPTH = (LOG2_INST_MEMORY_SIZE+1)'(INST_MEMORY_SIZE);
  logic [INST_WIDTH-1:0] mem [INST_MEMORY_SIZE];
  state_t state;
  logic [LOG2_INST_MEMORY_SIZE:0] len, clamp;
  logic [LOG2_INST_MEMORY_SIZE-1:0] pc;
  logic [INST_WIDTH-1:0] nxt;
  logic [OPCODE_W-1:0] d_op;
  logic [BUF_ID_W-1:0] d_buf;
  logic [MEM_LOC_W-1:0] d_loc;
  logic d_legal, last, adv;
  function automatic logic [INST_WIDTH-1:0] rd(input logic [LOG2_INST_MEMORY_SIZE-1:0] a);
    return {1'b0, a} < DEPTH ? mem[a] : '0;
  endfunction
  assign clamp = i_prog_len > DEPTH ? DEPTH : i_prog_len;
  assign last = {1'b0, pc} == len - 1'b1;
  assign adv = !o_inst_valid || i_inst_ready;
`ifdef INST_FETCH_PREFETCH_EN
  logic [INST_WIDTH-1:0] pf;
  assign nxt = state == ISSUE ? pf : rd(pc);
`else
  assign nxt = rd(pc);
`endif
  inst_decode u_decode (
    .word    (nxt),
    .opcode  (d_op),
    .buf_id  (d_buf),
    .mem_loc (d_loc),
    .legal   (d_legal)
  );
  // program store: cleared on reset, writable only while idle and in range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INST_MEMORY_SIZE; i++) mem[i] <= '0;
    end else if (state == IDLE && i_prog_wr_en && {1'b0, i_prog_wr_addr} < DEPTH) begin
      mem[i_prog_wr_addr] <= i_prog_wr_data;
    end
  end
  // sequencer: fetch into the issue register, hold until handshake, skip illegal words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      pc <= '0;
      o_inst_valid <= 1'b0;
      o_opcode <= '0;
      o_buf_id <= '0;
      o_mem_loc <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
      pf <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          len <= clamp;
          pc <= '0;
          o_err <= 1'b0;
          o_busy <= clamp != '0;
          state <= clamp == '0 ? DONE : FETCH;
        end
        FETCH: begin
          o_opcode <= d_op;
          o_buf_id <= d_buf;
          o_mem_loc <= d_loc;
          o_inst_valid <= d_legal;
`ifdef INST_FETCH_PREFETCH_EN
          pf <= rd(pc + 1'b1);
`endif
          state <= ISSUE;
        end
        ISSUE: if (adv) begin
          if (!o_inst_valid) o_err <= 1'b1;
          o_inst_valid <= 1'b0;
          if (last) begin
            o_busy <= 1'b0;
            state <= DONE;
          end else begin
            pc <= pc + 1'b1;
            state <= FETCH;
`ifdef INST_FETCH_PREFETCH_EN
            if (o_inst_valid) begin
              o_opcode <= d_op;
              o_buf_id <= d_buf;
              o_mem_loc <= d_loc;
              o_inst_valid <= d_legal;
              pf <= rd(pc + 2'd2);
              state <= ISSUE;
            end
`endif
          end
        end
        DONE: begin
          o_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch covering issue order, stalls, illegal skip, length clamp, reset and cadence
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_prog_wr_en = 1'b0;
  logic [2:0] i_prog_wr_addr = '0;
  logic [15:0] i_prog_wr_data = '0;
  logic [3:0] i_prog_len = '0;
  logic i_start = 1'b0;
  logic i_inst_ready = 1'b0;
  logic o_inst_valid, o_busy, o_done, o_err;
  logic [3:0] o_opcode;
  logic [1:0] o_buf_id;
  logic [9:0] o_mem_loc;
  int cyc = 0, n_chk = 0, n_fail = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  logic [15:0] exp_q[$], obs_q[$];
  int vq[$];

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_prog_wr_en   (i_prog_wr_en),
    .i_prog_wr_addr (i_prog_wr_addr),
    .i_prog_wr_data (i_prog_wr_data),
    .i_prog_len     (i_prog_len),
    .i_start        (i_start),
    .o_inst_valid   (o_inst_valid),
    .i_inst_ready   (i_inst_ready),
    .o_opcode       (o_opcode),
    .o_buf_id       (o_buf_id),
    .o_mem_loc      (o_mem_loc),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o_inst_valid) vq.push_back(cyc);
    if (o_inst_valid && i_inst_ready) obs_q.push_back({o_opcode, o_buf_id, o_mem_loc});
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic bit legal(input logic [15:0] w);
    return w[15:12] inside {4'h2, 4'h3, 4'h4, 4'h5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] w);
    i_prog_wr_en = 1'b1;
    i_prog_wr_addr = a;
    i_prog_wr_data = w;
    if (legal(w)) exp_q.push_back(w);
    tick();
    i_prog_wr_en = 1'b0;
  endtask

  task automatic start(input logic [3:0] l);
    i_start = 1'b1;
    i_prog_len = l;
    tick();
    start_cyc = cyc;
    i_start = 1'b0;
    vq.delete();
    obs_q.delete();
  endtask

  task automatic wait_done(input int base, output bit ok);
    int n = 0;
    while (done_cnt == base && n < 60) begin
      tick();
      n++;
    end
    ok = done_cnt != base;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({o_inst_valid, o_opcode, o_buf_id, o_mem_loc, o_busy, o_done, o_err} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected all zero", {o_inst_valid, o_opcode, o_buf_id, o_mem_loc, o_busy, o_done, o_err});
    end
  endtask

  task automatic test_single();
    int base = done_cnt;
    int first;
    bit ok;
    logic [15:0] e, o;
    exp_q.delete();
    exp_q.push_back(16'h2405);
    i_inst_ready = 1'b1;
    i_prog_wr_en = 1'b1;
    i_prog_wr_addr = 3'd0;
    i_prog_wr_data = 16'h2405;
    start(4'd1);
    i_prog_wr_en = 1'b0;
    wait_done(base, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL single_done: no o_done seen"); end
    first = vq.size() != 0 ? vq[0] : -1;
    n_chk++;
    if (first != start_cyc + 1 || vq.size() != 1) begin
      n_fail++;
      $display("FAIL single_latency: first valid cycle %0d count %0d, expected %0d count 1", first, vq.size(), start_cyc + 1);
    end
    n_chk++;
    if (done_cyc != start_cyc + 3) begin n_fail++; $display("FAIL single_done_time: got %0d, expected %0d", done_cyc, start_cyc + 3); end
    n_chk++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b, expected 0", o_err); end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL single_fields: got %h, expected %h", o, e); end
    end
  endtask

  task automatic test_stall();
    int base = done_cnt;
    bit ok, seen = 0;
    logic [15:0] e, o;
    exp_q.delete();
    load(3'd0, 16'h2405);
    load(3'd1, 16'h4000);
    load(3'd2, 16'h3802);
    load(3'd3, 16'h5000);
    i_inst_ready = 1'b1;
    start(4'd4);
    for (int n = 0; n < 30 && !seen; n++) begin
      if (o_inst_valid && o_opcode == 4'h4) seen = 1;
      else tick();
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL stall_gemm_seen: GEMM never became valid"); end
    if (seen) begin
      i_inst_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        n_chk++;
        if ({o_inst_valid, o_opcode, o_buf_id, o_mem_loc, o_busy} !== {1'b1, 4'h4, 2'd0, 10'd0, 1'b1}) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b op=%h buf=%0d loc=%0d busy=%b, expected v=1 op=4 buf=0 loc=0 busy=1", o_inst_valid, o_opcode, o_buf_id, o_mem_loc, o_busy);
        end
      end
      i_inst_ready = 1'b1;
    end
    wait_done(base, ok);
    repeat (3) tick();
    n_chk++;
    if (!ok || done_cnt != base + 1) begin n_fail++; $display("FAIL stall_done: got %0d done pulses, expected 1", done_cnt - base); end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL stall_order: got %h, expected %h", o, e); end
    end
  endtask

  task automatic test_illegal();
    int base = done_cnt;
    bit ok;
    logic [15:0] e, o;
    exp_q.delete();
    load(3'd0, 16'h2405);
    load(3'd1, 16'hF123);
    load(3'd2, 16'h5000);
    i_inst_ready = 1'b1;
    start(4'd3);
    wait_done(base, ok);
    n_chk++;
    if (!ok || o_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got err=%b done=%b, expected err=1 done=1", o_err, ok); end
    repeat (4) tick();
    n_chk++;
    if (o_err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky: got %b, expected 1", o_err); end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL illegal_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL illegal_order: got %h, expected %h", o, e); end
    end
  endtask

  task automatic test_len_edge();
    int base = done_cnt;
    bit ok;
    logic [15:0] e, o;
    logic [3:0] ops [4] = '{4'h2, 4'h3, 4'h4, 4'h5};
    i_inst_ready = 1'b1;
    start(4'd0);
    n_chk++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL start_clears_err: got %b, expected 0", o_err); end
    wait_done(base, ok);
    n_chk++;
    if (!ok || vq.size() != 0) begin n_fail++; $display("FAIL len0: done=%b valids=%0d, expected done=1 valids=0", ok, vq.size()); end
    exp_q.delete();
    for (int i = 0; i < 6; i++) load(3'(i), {ops[i % 4], 2'(i), 10'(i * 37 + 1)});
    base = done_cnt;
    start(4'd7);
    i_prog_wr_en = 1'b1;
    i_prog_wr_addr = 3'd0;
    i_prog_wr_data = 16'h5FFF;
    tick();
    i_prog_wr_en = 1'b0;
    wait_done(base, ok);
    n_chk++;
    if (!ok || obs_q.size() != 6) begin n_fail++; $display("FAIL len7_clamp: got %0d handshakes, expected 6", obs_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL len7_order: got %h, expected %h", o, e); end
    end
    exp_q.delete();
    base = done_cnt;
    start(4'd1);
    wait_done(base, ok);
    o = obs_q.size() != 0 ? obs_q[0] : 16'hxxxx;
    n_chk++;
    if (!ok || o !== {4'h2, 2'd0, 10'd1}) begin n_fail++; $display("FAIL busy_write_dropped: got %h, expected %h", o, {4'h2, 2'd0, 10'd1}); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok, seen = 0;
    exp_q.delete();
    load(3'd0, 16'h2405);
    i_inst_ready = 1'b0;
    start(4'd1);
    for (int n = 0; n < 10 && !seen; n++) begin
      if (o_inst_valid) seen = 1;
      else tick();
    end
    base = done_cnt;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (!seen || {o_inst_valid, o_opcode, o_buf_id, o_mem_loc, o_busy, o_done, o_err} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid: seen=%b outputs=%b, expected seen=1 outputs zero", seen, {o_inst_valid, o_opcode, o_buf_id, o_mem_loc, o_busy, o_done, o_err});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (done_cnt != base) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses, expected 0", done_cnt - base); end
    exp_q.delete();
    i_inst_ready = 1'b1;
    start(4'd1);
    wait_done(base, ok);
    n_chk++;
    if (!ok || obs_q.size() != 0 || vq.size() != 0 || o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cleared_store: done=%b valids=%0d err=%b, expected done=1 valids=0 err=1", ok, vq.size(), o_err);
    end
  endtask

  task automatic test_cadence();
    int base = done_cnt;
    int step;
    bit ok;
`ifdef INST_FETCH_PREFETCH_EN
    step = 1;
`else
    step = 2;
`endif
    exp_q.delete();
    load(3'd0, 16'h2011);
    load(3'd1, 16'h4422);
    load(3'd2, 16'h3833);
    load(3'd3, 16'h5C44);
    i_inst_ready = 1'b1;
    start(4'd4);
    wait_done(base, ok);
    n_chk++;
    if (!ok || vq.size() != 4) begin n_fail++; $display("FAIL cadence_count: got %0d valid cycles, expected 4", vq.size()); end
    if (vq.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        n_chk++;
        if (vq[i] - vq[i-1] != step) begin n_fail++; $display("FAIL cadence_gap: got %0d, expected %0d", vq[i] - vq[i-1], step); end
      end
    end
    n_chk++;
    if (obs_q.size() != 4 || obs_q[3] !== 16'h5C44) begin n_fail++; $display("FAIL cadence_last: got %0d handshakes, expected 4 ending 5c44", obs_q.size()); end
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single();
    test_stall();
    test_illegal();
    test_len_edge();
    test_reset_mid();
    test_cadence();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
